// File: rtl/llc_mem_responder.sv
// Main-memory model below the LLC: serves one line fill (read) or writeback (write) at a time,
// streaming NBEATS beats per line with a fixed read latency and a sticky wlast-mismatch error.
module llc_mem_responder #(
  parameter int LINE_SIZE    = 64,
  parameter int BEAT_BYTES   = 8,
  parameter int READ_LATENCY = 4,
  parameter int MEM_LINES    = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [8*BEAT_BYTES-1:0] wdata,
  input  logic                    wlast,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [8*BEAT_BYTES-1:0] rdata,
  output logic                    rlast,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    berr
);

  localparam int NBEATS = LINE_SIZE / BEAT_BYTES;
  localparam int DW     = 8 * BEAT_BYTES;
  localparam int MIDX   = $clog2(MEM_LINES);
  localparam int BW     = $clog2(NBEATS);
  localparam int OFF    = $clog2(LINE_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_LAT, S_RDATA, S_WDATA, S_WRESP} state_t;

  state_t               r_state;
  logic [MIDX-1:0]      r_idx;
  logic [BW-1:0]        r_beat;
  logic [7:0]           r_lat;
  logic                 r_err;
  logic [MEM_LINES-1:0] r_written;
  logic [DW-1:0]        r_mem [MEM_LINES*NBEATS];

  logic          r_req_ready, r_wready, r_rvalid, r_rlast, r_bvalid, r_berr;
  logic [DW-1:0] r_rdata;

  logic [MIDX-1:0] w_req_idx;
  logic [BW-1:0]   w_next_beat;
  logic            w_last_beat, w_wlast_err, w_wr_fire, w_unused;
  logic [DW-1:0]   w_beat0_data, w_next_data;

  // Unwritten lines return byte i = (index + i) mod 256 so fills are recognisable without preload.
  function automatic logic [DW-1:0] beat_data(input logic [MIDX-1:0] idx, input logic [BW-1:0] beat);
    logic [DW-1:0] d;
    d = r_mem[{idx, beat}];
    if (!r_written[idx]) begin
      for (int k = 0; k < BEAT_BYTES; k++)
        d[8*k +: 8] = 8'(idx) + 8'(beat) * 8'(BEAT_BYTES) + 8'(k);
    end
    return d;
  endfunction

  assign w_req_idx    = req_addr[OFF +: MIDX];
  assign w_unused     = ^{req_addr[31:OFF+MIDX], req_addr[OFF-1:0]};
  assign w_next_beat  = r_beat + 1'b1;
  assign w_last_beat  = (r_beat == BW'(NBEATS - 1));
  assign w_wlast_err  = (wlast != w_last_beat);
  assign w_wr_fire    = (r_state == S_WDATA) && wvalid;
  assign w_beat0_data = beat_data(r_idx, '0);
  assign w_next_data  = beat_data(r_idx, w_next_beat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_beat      <= '0;
      r_lat       <= '0;
      r_err       <= 1'b0;
      r_written   <= '0;
      r_req_ready <= 1'b1;
      r_wready    <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
      r_bvalid    <= 1'b0;
      r_berr      <= 1'b0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_idx       <= w_req_idx;
            r_beat      <= '0;
            r_req_ready <= 1'b0;
            if (req_write) begin
              r_state  <= S_WDATA;
              r_wready <= 1'b1;
            end else begin
              r_state <= S_LAT;
              r_lat   <= 8'(READ_LATENCY - 1);
            end
          end
        end
        S_LAT: begin
          if (r_lat == 8'd0) begin
            r_state  <= S_RDATA;
            r_rvalid <= 1'b1;
            r_rdata  <= w_beat0_data;
            r_rlast  <= (NBEATS == 1);
          end else begin
            r_lat <= r_lat - 8'd1;
          end
        end
        S_RDATA: begin
          if (rready) begin
            if (w_last_beat) begin
              r_state     <= S_IDLE;
              r_rvalid    <= 1'b0;
              r_rlast     <= 1'b0;
              r_rdata     <= '0;
              r_req_ready <= 1'b1;
            end else begin
              r_beat  <= w_next_beat;
              r_rdata <= w_next_data;
              r_rlast <= (w_next_beat == BW'(NBEATS - 1));
            end
          end
        end
        S_WDATA: begin
          if (wvalid) begin
            if (w_wlast_err) r_err <= 1'b1;
            if (w_last_beat) begin
              r_written[r_idx] <= 1'b1;
              r_state          <= S_WRESP;
              r_wready         <= 1'b0;
              r_bvalid         <= 1'b1;
              r_berr           <= r_err | w_wlast_err;
            end else begin
              r_beat <= w_next_beat;
            end
          end
        end
        S_WRESP: begin
          if (bready) begin
            r_state     <= S_IDLE;
            r_bvalid    <= 1'b0;
            r_berr      <= 1'b0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the line store has no reset; only the per-line written flags are cleared.
  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[{r_idx, r_beat}] <= wdata;
  end

  assign req_ready = r_req_ready;
  assign wready    = r_wready;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign rlast     = r_rlast;
  assign bvalid    = r_bvalid;
  assign berr      = r_berr;

endmodule
